mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative RV64M multiply/divide unit in the execute stage. Consumes the same
//  rd1 / rd2 operands that the operand muxes feed to the ALU. Runs MUL* / DIV* / REM*,
//  including the W variants, over multiple cycles. Stalls the pipeline through a
//  valid/ready handshake until the result is written back into the EX result path.
// PARAMETERS
//  ITER_PER_CYCLE  1  shift/subtract steps per clock; legal values 1, 2, 4.
//                     Busy latency = 64/ITER_PER_CYCLE cycles.
// PORTS
//  clk        in   1   clock, all state on the rising edge
//  reset      in   1   asynchronous, active-high; all state and outputs clear immediately
//  flush      in   1   synchronous abort (branch mispredict / trap)
//  in_valid   in   1   operation request
//  in_ready   out  1   high only in IDLE
//  op         in   3   MDUOpType: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//  word       in   1   W variant (operates on [31:0]; result sign-extended from bit 31)
//  rd1        in   64  operand a (from the rd1 mux)
//  rd2        in   64  operand b (from rd2_imm_mux, ALUSRC = FromReg)
//  out_valid  out  1   result available
//  out_ready  in   1   consumer accepts the result
//  result     out  64  final value
//  busy       out  1   state != IDLE (hazard unit stalls IF/ID/EX)
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, result=0, busy=0, state=IDLE.
//  FSM states:
//   IDLE -> BUSY on in_valid & in_ready & ~flush. On that edge:
//     - latch op and word;
//     - sign- or zero-extend each operand per op/word (W: extend from bit 31);
//     - cnt=0.
//   BUSY: each cycle performs ITER_PER_CYCLE steps.
//     - MUL*: shift-add into a 128-bit {hi,lo} accumulator over unsigned magnitudes.
//     - DIV*/REM*: restoring division over magnitudes.
//     - cnt increments; on cnt reaching 64/ITER_PER_CYCLE-1 -> DONE.
//   DONE: out_valid=1 and result is held stable; -> IDLE on out_ready.
//  Result selection:
//   - MUL = lo; MULH / MULHSU / MULHU = hi.
//   - Sign fixup: negate the product when operand signs differ; quotient likewise;
//     remainder takes the dividend sign.
//   - W: result = {{32{r[31]}}, r[31:0]}.
//  Latency: accept edge + 64/ITER_PER_CYCLE busy cycles; out_valid is high on the next cycle.
//  Corner values:
//   - Divide by zero: quotient = all ones; remainder = dividend (extended per W).
//   - Signed overflow (MIN / -1, MIN = 2^63, or 2^31 for W): quotient = MIN (sign-extended);
//     remainder = 0.
//  Handshake and flush:
//   - New op is accepted only in IDLE. A result taken in DONE frees the unit one cycle later.
//   - flush in BUSY or DONE -> IDLE next edge; out_valid drops; no result is produced.
//   - flush and in_valid in IDLE: flush wins, nothing is accepted.
//   - out_ready held low keeps DONE indefinitely; result and out_valid are stable.
//   - Asynchronous reset mid-operation: immediate return to IDLE; partial state is discarded.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined:
//   - Divide by zero and signed overflow go IDLE -> DONE directly, giving
//     out_valid on the cycle after accept.
//   - Also, MUL* with either operand 0 completes early with result 0.
//  MDU_EARLY_OUT_EN undefined:
//   - These cases run the full busy latency.
//   - Result values are identical either way.
// STRUCTURE
//  - pipes package: MDUOpType enum and MDUStateType {IDLE, BUSY, DONE}.
//  - common package: u64 and u6 typedefs.
//  - Sub-module mdu_step (combinational): one shift-add / restore-subtract step,
//    instantiated ITER_PER_CYCLE times in a chain.
//  - Operand prep, sign fixup and the FSM stay in mdu_iter.
// TESTING
//  1. MUL rd1=7, rd2=-3 -> result 0xFFFF_FFFF_FFFF_FFEB; out_valid 65 cycles after accept
//     (ITER_PER_CYCLE=1).
//  2. MULHU 0xFFFF_FFFF_FFFF_FFFF x 2 -> 0x1; MULH same operands -> 0xFFFF_FFFF_FFFF_FFFF.
//  3. DIV -7 / 2 -> -3; REM -7 / 2 -> -1; DIVUW 0x1_8000_0000 / 1 -> 0xFFFF_FFFF_8000_0000.
//  4. DIV x / 0 -> all ones; REMU 5 / 0 -> 5; DIV 0x8000_0000_0000_0000 / -1 -> same value,
//     REM -> 0. With MDU_EARLY_OUT_EN the latency is 1.
//  5. flush at busy cycle 10 -> out_valid never rises; in_ready=1 next cycle; the next op
//     completes correctly.
//  6. out_ready low for 5 cycles in DONE -> result stable; async reset pulse mid-BUSY ->
//     outputs go to reset values immediately.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared types and result helpers for the iterative RV64M multiply/divide unit
// Contents: u64/u6 typedefs, MDUOpType, MDUStateType, wext (W-variant extension), fixup (sign fixup + result select)
package mdu_iter_pkg;
    typedef logic [63:0] u64;
    typedef logic [5:0] u6;
    typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} MDUOpType;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} MDUStateType;

    function automatic u64 wext(logic word, u64 r);
        return word ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

    // hi/lo hold the unsigned product, or remainder/quotient for divides
    function automatic u64 fixup(MDUOpType op, logic word, logic neg, u64 hi, u64 lo);
        logic [127:0] p;
        u64 x;
        p = neg ? -{hi, lo} : {hi, lo};
        x = op[1] ? hi : lo;
        return wext(word, op[2] ? (neg ? -x : x) : (op == MUL ? p[63:0] : p[127:64]));
    endfunction
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/response handshake between the EX stage and the multiply/divide unit
// Signals: flush, in_valid/in_ready, op, word, rd1, rd2, out_valid/out_ready, result, busy
// Modports: master (EX stage side), slave (mdu_iter side)
interface mdu_iter_if;
    import mdu_iter_pkg::*;
    logic flush;
    logic in_valid;
    logic in_ready;
    MDUOpType op;
    logic word;
    u64 rd1;
    u64 rd2;
    logic out_valid;
    logic out_ready;
    u64 result;
    logic busy;

    modport master(output flush, in_valid, op, word, rd1, rd2, out_ready,
                   input in_ready, out_valid, result, busy);
    modport slave(input flush, in_valid, op, word, rd1, rd2, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_step: one combinational shift-add (multiply) or restoring-subtract (divide) step
// Ports: is_div, m (multiplicand/divisor), hi/lo (accumulator in), hi_n/lo_n (accumulator out)
module mdu_step
    import mdu_iter_pkg::*;
(
    input  logic is_div,
    input  u64   m,
    input  u64   hi,
    input  u64   lo,
    output u64   hi_n,
    output u64   lo_n
);
    logic [64:0] sum, t, diff;

    // Multiply consumes the multiplier from lo LSB-first; divide shifts the dividend
    // out of lo MSB-first and shifts quotient bits back in.
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : 65'd0);
        t    = {hi, lo[63]};
        diff = t - {1'b0, m};
        hi_n = is_div ? (diff[64] ? t[63:0] : diff[63:0]) : sum[64:1];
        lo_n = is_div ? {lo[62:0], ~diff[64]} : {sum[0], lo[63:1]};
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV64M multiply/divide unit with valid/ready handshake and flush
// Ports: clk, reset (async active-high), bus (mdu_iter_if.slave)
// Parameter: ITER_PER_CYCLE (1, 2 or 4 steps per clock)
// Macro: MDU_EARLY_OUT_EN finishes divide-by-zero, signed overflow and zero-operand multiplies right after accept
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int ITER_PER_CYCLE = 1
) (
    input logic clk,
    input logic reset,
    mdu_iter_if.slave bus
);
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam u6 LAST = u6'(64 / ITER_PER_CYCLE - 1);
    localparam u64 MIN64 = 64'h8000_0000_0000_0000;
    localparam u64 MIN32 = 64'hFFFF_FFFF_8000_0000;

    MDUStateType state;
    MDUOpType op_q;
    logic word_q, neg_q, spec_q;
    u64 spec_val_q, m, hi, lo, hn, ln;
    u6 cnt;

    logic sgn_a, sgn_b, neg_a, neg_b, div_zero, ovf, mul_zero, special, neg;
    u64 ea, eb, ma, mb, spec_val;

    always_comb begin
        sgn_a    = bus.op inside {MULH, MULHSU, DIV, REM};
        sgn_b    = bus.op inside {MULH, DIV, REM};
        ea       = bus.word ? {{32{sgn_a & bus.rd1[31]}}, bus.rd1[31:0]} : bus.rd1;
        eb       = bus.word ? {{32{sgn_b & bus.rd2[31]}}, bus.rd2[31:0]} : bus.rd2;
        neg_a    = sgn_a & ea[63];
        neg_b    = sgn_b & eb[63];
        ma       = neg_a ? -ea : ea;
        mb       = neg_b ? -eb : eb;
        div_zero = bus.op[2] & (eb == '0);
        ovf      = bus.op[2] & sgn_b & (ea == (bus.word ? MIN32 : MIN64)) & (eb == '1);
        mul_zero = ~bus.op[2] & ((ea == '0) | (eb == '0));
        special  = div_zero | ovf | mul_zero;
        // ea is already the extended dividend, which is both MIN and the div-by-zero remainder
        spec_val = div_zero ? (bus.op[1] ? wext(bus.word, ea) : '1) : (ovf & ~bus.op[1]) ? ea : '0;
        // remainder follows the dividend sign only
        neg      = neg_a ^ (neg_b & ~(bus.op[2] & bus.op[1]));
    end

    for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : stg
        u64 h_in, l_in, h_out, l_out;
        if (i == 0) begin : g_first
            assign h_in = hi;
            assign l_in = lo;
        end else begin : g_next
            assign h_in = stg[i-1].h_out;
            assign l_in = stg[i-1].l_out;
        end
        mdu_step u_step (
            .is_div(op_q[2]),
            .m     (m),
            .hi    (h_in),
            .lo    (l_in),
            .hi_n  (h_out),
            .lo_n  (l_out)
        );
    end
    assign hn = stg[ITER_PER_CYCLE-1].h_out;
    assign ln = stg[ITER_PER_CYCLE-1].l_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            op_q          <= MUL;
            word_q        <= 1'b0;
            neg_q         <= 1'b0;
            spec_q        <= 1'b0;
            spec_val_q    <= '0;
            m             <= '0;
            hi            <= '0;
            lo            <= '0;
            cnt           <= '0;
            bus.result    <= '0;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
        end else if (bus.flush) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op_q         <= bus.op;
                    word_q       <= bus.word;
                    neg_q        <= neg;
                    spec_q       <= special;
                    spec_val_q   <= spec_val;
                    m            <= bus.op[2] ? mb : ma;
                    lo           <= bus.op[2] ? ma : mb;
                    hi           <= '0;
                    cnt          <= '0;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b1;
                    if (EARLY && special) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= spec_val;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    hi  <= hn;
                    lo  <= ln;
                    cnt <= cnt + u6'(1);
                    if (cnt == LAST) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= spec_q ? spec_val_q : fixup(op_q, word_q, neg_q, hn, ln);
                    end
                end
                DONE: if (bus.out_ready) begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized self-checking bench for mdu_iter against an arithmetic reference model
module tb_mdu_iter;
    import mdu_iter_pkg::*;
    localparam int IPC = 1;
`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_pass = 0;

    mdu_iter_if bus();
    mdu_iter #(.ITER_PER_CYCLE(IPC)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] sext32(logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    // RISC-V M semantics: truncating division, x/0 = all ones, x%0 = x, MIN/-1 = MIN rem 0
    function automatic logic [63:0] ref_mdu(logic [2:0] op, bit w, logic [63:0] a, logic [63:0] b);
        logic [127:0] wa, wb, p;
        logic [63:0] x, y, mx, my, q, r;
        bit s, sx, sy;
        if (!op[2]) begin
            wa = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'b0, a};
            wb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
            p = wa * wb;
            x = (op == 3'd0) ? p[63:0] : p[127:64];
            return w ? sext32(x) : x;
        end
        s = (op == 3'd4 || op == 3'd6);
        x = w ? (s ? sext32(a) : {32'b0, a[31:0]}) : a;
        y = w ? (s ? sext32(b) : {32'b0, b[31:0]}) : b;
        if (y == 0) begin
            r = op[1] ? x : '1;
        end else begin
            sx = s && x[63];
            sy = s && y[63];
            mx = sx ? -x : x;
            my = sy ? -y : y;
            q = mx / my;
            r = mx % my;
            r = op[1] ? (sx ? -r : r) : ((sx ^ sy) ? -q : q);
        end
        return w ? sext32(r) : r;
    endfunction

    // edges from accept (inclusive) to the edge that raises out_valid
    function automatic int ref_lat(logic [2:0] op, bit w, logic [63:0] a, logic [63:0] b);
        logic [63:0] x, y, mn;
        bit early;
        x = w ? {32'b0, a[31:0]} : a;
        y = w ? {32'b0, b[31:0]} : b;
        mn = w ? 64'h8000_0000 : MIN;
        early = op[2] ? (y == 0 || ((op == 3'd4 || op == 3'd6) && x == mn && y == (w ? 64'hFFFF_FFFF : '1)))
                      : (x == 0 || y == 0);
        return (EARLY && early) ? 1 : 1 + 64 / IPC;
    endfunction

    task automatic run(input logic [2:0] op, input bit w, input logic [63:0] a, input logic [63:0] b,
                       input string tag, input int hold);
        logic [63:0] exp;
        int lat;
        exp = ref_mdu(op, w, a, b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = MDUOpType'(op);
        bus.word = w;
        bus.rd1 = a;
        bus.rd2 = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 64'({bus.busy, bus.in_ready}), 64'b10);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(ref_lat(op, w, a, b)));
        chk(tag, bus.result, exp);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_hold_r"}, bus.result, exp);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_free"}, 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = MIN;
            3: v = 64'($urandom_range(0, 10));
            4: v = {32'b0, $urandom};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    initial begin
        logic seen;
        logic [2:0] op;
        bit w;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.op = MUL;
        bus.word = 1'b0;
        bus.rd1 = '0;
        bus.rd2 = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
        chk("reset_res", bus.result, '0);
        reset = 1'b0;

        run(MUL, 0, 64'd7, -64'd3, "mul_7_m3", 5);
        run(MULHU, 0, '1, 64'd2, "mulhu", 0);
        run(MULH, 0, '1, 64'd2, "mulh", 0);
        run(MULHSU, 0, -64'd5, 64'd3, "mulhsu", 0);
        run(DIV, 0, -64'd7, 64'd2, "div_m7_2", 0);
        run(REM, 0, -64'd7, 64'd2, "rem_m7_2", 0);
        run(DIVU, 1, 64'h1_8000_0000, 64'd1, "divuw", 0);
        run(DIV, 0, 64'd123, 64'd0, "div_by0", 0);
        run(REMU, 0, 64'd5, 64'd0, "remu_by0", 0);
        run(DIV, 0, MIN, '1, "div_ovf", 0);
        run(REM, 0, MIN, '1, "rem_ovf", 0);
        run(DIV, 1, 64'h8000_0000, '1, "divw_ovf", 0);
        run(REMU, 1, 64'hF_8765_4321, 64'd0, "remuw_by0", 0);
        run(MUL, 0, 64'd0, 64'd99, "mul_zero", 0);

        // flush mid-BUSY: no result, unit free next cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = DIV;
        bus.word = 1'b0;
        bus.rd1 = 64'd1000;
        bus.rd2 = 64'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_idle", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        chk("flush_noval", 64'(seen), 64'd0);
        run(DIV, 0, 64'd1000, 64'd7, "after_flush", 0);

        // flush beats in_valid in IDLE
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush_wins", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        chk("flush_wins_noval", 64'(seen), 64'd0);

        // asynchronous reset between clock edges while BUSY
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = MUL;
        bus.rd1 = 64'd11;
        bus.rd2 = 64'd13;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset_ctl", 64'({bus.out_valid, bus.busy, bus.in_ready}), 64'b001);
        chk("areset_res", bus.result, '0);
        @(negedge clk);
        reset = 1'b0;
        run(MUL, 0, 64'd11, 64'd13, "after_reset", 0);

        for (int n = 0; n < 30; n++) begin
            op = 3'($urandom_range(0, 7));
            w = (op == 3'd0 || op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            run(op, w, rnd_operand(), rnd_operand(), $sformatf("rnd%0d_op%0d_w%0d", n, op, w), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
